// File: rtl/div_pkg.sv
// Shared definitions for the divider result packer: default word length and
// the canonical result-entry layout held in the output buffer.
package div_pkg;

  localparam int DIV_WORD_LENGTH = 16;

  typedef struct packed {
    logic [DIV_WORD_LENGTH-1:0] quotient;
    logic [DIV_WORD_LENGTH-1:0] remainder;
    logic                       div0;
  } div_result_t;

endpackage

// File: rtl/div_result_fifo.sv
// Small power-of-two FIFO holding signed divider results, with a sticky flag
// recording any result dropped while the buffer was full.
module div_result_fifo
  import div_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = div_result_t
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  entry_t                 i_data,
  input  logic                   i_pop,
  output entry_t                 o_head,
  output logic                   o_valid,
  output logic                   o_full,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;

  logic w_pop;
  logic w_push;
  logic w_drop;

  assign o_valid = (r_count != '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));

  // A pop frees a slot in the same cycle, so a full buffer still accepts a push.
  assign w_pop  = i_pop && o_valid;
  assign w_push = i_push && (!o_full || w_pop);
  assign w_drop = i_push && o_full && !w_pop;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset && w_push) begin
      r_mem[r_wrPtr] <= i_data;
    end
  end

  // Empty buffer presents zeros so stale entries never leak after reset.
  assign o_head     = o_valid ? r_mem[r_rdPtr] : '0;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/div_result_packer.sv
// Converts unsigned divider magnitudes plus sign bits into two's-complement
// quotient/remainder entries and buffers them for a ready/valid consumer.
module div_result_packer
  import div_pkg::*;
#(
  parameter int WORD_LENGTH = DIV_WORD_LENGTH,
  parameter int DEPTH       = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [WORD_LENGTH-1:0] quotient_mag,
  input  logic [WORD_LENGTH-1:0] remainder_mag,
  input  logic                   sign,
  input  logic                   dividend_sign,
  input  logic                   divisor_zero,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [WORD_LENGTH-1:0] out_quotient,
  output logic [WORD_LENGTH-1:0] out_remainder,
  output logic                   out_div0,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  typedef struct packed {
    logic [WORD_LENGTH-1:0] quotient;
    logic [WORD_LENGTH-1:0] remainder;
    logic                   div0;
  } result_t;

  result_t w_entry;
  result_t w_head;

  // Remainder takes the dividend's sign; a divide-by-zero forces quotient to all ones.
  always_comb begin
    w_entry.quotient  = sign ? (~quotient_mag + 1'b1) : quotient_mag;
    w_entry.remainder = dividend_sign ? (~remainder_mag + 1'b1) : remainder_mag;
    w_entry.div0      = divisor_zero;
    if (divisor_zero) begin
      w_entry.quotient = '1;
    end
  end

  div_result_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (result_t)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push     (in_valid),
    .i_data     (w_entry),
    .i_pop      (out_ready),
    .o_head     (w_head),
    .o_valid    (out_valid),
    .o_full     (full),
    .o_count    (count),
    .o_overflow (overflow)
  );

  assign out_quotient  = w_head.quotient;
  assign out_remainder = w_head.remainder;
  assign out_div0      = w_head.div0;

endmodule

// File: tb/tb_div_result_packer.sv
// Self-checking bench for div_result_packer: table-driven sign-fix vectors plus
// hand-written buffer sequences, with a queue scoreboard checking FIFO order.
module tb_div_result_packer;

  localparam int WL    = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [WL-1:0] quotient_mag;
  logic [WL-1:0] remainder_mag;
  logic          sign;
  logic          dividend_sign;
  logic          divisor_zero;
  logic          out_ready;
  logic          out_valid;
  logic [WL-1:0] out_quotient;
  logic [WL-1:0] out_remainder;
  logic          out_div0;
  logic          full;
  logic [2:0]    count;
  logic          overflow;

  div_result_packer #(
    .WORD_LENGTH (WL),
    .DEPTH       (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .quotient_mag  (quotient_mag),
    .remainder_mag (remainder_mag),
    .sign          (sign),
    .dividend_sign (dividend_sign),
    .divisor_zero  (divisor_zero),
    .out_ready     (out_ready),
    .out_valid     (out_valid),
    .out_quotient  (out_quotient),
    .out_remainder (out_remainder),
    .out_div0      (out_div0),
    .full          (full),
    .count         (count),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WL-1:0] q;
    logic [WL-1:0] r;
    logic          d;
  } exp_t;

  typedef struct {
    logic [WL-1:0] qMag;
    logic [WL-1:0] rMag;
    logic          sgn;
    logic          dSgn;
    logic          dz;
    logic [WL-1:0] expQ;
    logic [WL-1:0] expR;
    logic          expD;
  } vec_t;

  exp_t expQueue[$];
  logic modelOverflow = 1'b0;
  int   checks = 0;
  int   failures = 0;

  // Comparison helper; every check in the bench funnels through here.
  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [WL-1:0] qMag, input logic [WL-1:0] rMag,
                               input logic sgn, input logic dSgn, input logic dz,
                               input logic valid, input logic ready);
    quotient_mag  = qMag;
    remainder_mag = rMag;
    sign          = sgn;
    dividend_sign = dSgn;
    divisor_zero  = dz;
    in_valid      = valid;
    out_ready     = ready;
  endtask

  // Reference sign-fix, written with arithmetic negation.
  function automatic exp_t modelEntry();
    exp_t e;
    e.q = divisor_zero ? {WL{1'b1}} : (sign ? WL'(0 - int'(quotient_mag)) : quotient_mag);
    e.r = dividend_sign ? WL'(0 - int'(remainder_mag)) : remainder_mag;
    e.d = divisor_zero;
    return e;
  endfunction

  // Advance one clock: score any pop, model any push/drop, then check status.
  task automatic cycle(input string tag);
    bit popping;
    popping = 1'b0;
    if (!reset) begin
      expQueue.delete();
      modelOverflow = 1'b0;
    end else begin
      if (out_ready && expQueue.size() > 0) begin
        popping = 1'b1;
        checkVal({tag, ".popQ"}, 32'(out_quotient), 32'(expQueue[0].q));
        checkVal({tag, ".popR"}, 32'(out_remainder), 32'(expQueue[0].r));
        checkVal({tag, ".popD"}, 32'(out_div0), 32'(expQueue[0].d));
        void'(expQueue.pop_front());
      end
      if (in_valid) begin
        if (expQueue.size() < DEPTH) expQueue.push_back(modelEntry());
        else modelOverflow = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    checkVal({tag, ".count"}, 32'(count), 32'(expQueue.size()));
    checkVal({tag, ".valid"}, 32'(out_valid), 32'(expQueue.size() != 0));
    checkVal({tag, ".full"}, 32'(full), 32'(expQueue.size() == DEPTH));
    checkVal({tag, ".ovf"}, 32'(overflow), 32'(modelOverflow));
  endtask

  task automatic checkOutput(input string tag, input logic [WL-1:0] q,
                             input logic [WL-1:0] r, input logic d);
    checkVal({tag, ".headQ"}, 32'(out_quotient), 32'(q));
    checkVal({tag, ".headR"}, 32'(out_remainder), 32'(r));
    checkVal({tag, ".headD"}, 32'(out_div0), 32'(d));
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{16'd7,      16'd2,    1'b1, 1'b1, 1'b0, 16'hFFF9, 16'hFFFE, 1'b0};
    vecs[1] = '{16'd5,      16'd0,    1'b0, 1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0};
    vecs[2] = '{16'd0,      16'd9,    1'b0, 1'b0, 1'b1, 16'hFFFF, 16'h0009, 1'b1};
    vecs[3] = '{16'd0,      16'd0,    1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
    vecs[4] = '{16'h8000,   16'd1,    1'b1, 1'b0, 1'b0, 16'h8000, 16'h0001, 1'b0};
    vecs[5] = '{16'd1,      16'd1,    1'b1, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0};
    vecs[6] = '{16'd12,     16'd3,    1'b1, 1'b1, 1'b1, 16'hFFFF, 16'hFFFD, 1'b1};
    vecs[7] = '{16'h1234,   16'h0010, 1'b0, 1'b1, 1'b0, 16'h1234, 16'hFFF0, 1'b0};

    // Reset with in_valid asserted: must be ignored.
    reset = 1'b0;
    applyStimulus(16'd3, 16'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle("rst0");
    cycle("rst1");
    reset = 1'b1;
    applyStimulus('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle("rstIdle");
    checkOutput("rstOut", 16'h0000, 16'h0000, 1'b0);

    // Sign-fix table: each vector pushed alone, visible next cycle, then popped.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].qMag, vecs[i].rMag, vecs[i].sgn, vecs[i].dSgn, vecs[i].dz, 1'b1, 1'b0);
      cycle($sformatf("vec%0d.push", i));
      checkOutput($sformatf("vec%0d", i), vecs[i].expQ, vecs[i].expR, vecs[i].expD);
      applyStimulus('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle($sformatf("vec%0d.pop", i));
    end

    // Five pushes with no consumer: fifth dropped, overflow sticky, head stable.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(16'(10 + i), 16'(i), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      cycle($sformatf("ovf.push%0d", i));
    end
    checkOutput("ovf.head", 16'd10, 16'd0, 1'b0);
    applyStimulus('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cycle($sformatf("ovf.drain%0d", i));
    reset = 1'b0;
    applyStimulus('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle("ovf.rst");
    reset = 1'b1;
    cycle("ovf.idle");

    // Full buffer with simultaneous push and pop: accepted, new entry fourth.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(16'(20 + i), 16'(i), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      cycle($sformatf("fpp.fill%0d", i));
    end
    applyStimulus(16'd99, 16'd7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    cycle("fpp.both");
    applyStimulus('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle($sformatf("fpp.drain%0d", i));

    // Count of one with simultaneous push and pop: new entry becomes head.
    applyStimulus(16'd4, 16'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle("one.push");
    applyStimulus(16'd6, 16'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle("one.both");
    checkOutput("one.head", 16'hFFFA, 16'h0002, 1'b0);
    applyStimulus('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle("one.drain");

    // Three held entries discarded by a one-cycle reset with in_valid high.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(16'(30 + i), 16'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      cycle($sformatf("mid.push%0d", i));
    end
    reset = 1'b0;
    applyStimulus(16'd77, 16'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle("mid.rst");
    checkOutput("mid.out", 16'h0000, 16'h0000, 1'b0);
    reset = 1'b1;
    applyStimulus('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle("mid.idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_result_packer.md
DIV_RESULT_PACKER -- requirements
Module: div_result_packer

Interface
REQ-001 Parameter: WORD_LENGTH, default 16, operand/result width in bits.
REQ-002 Parameter: DEPTH, default 4, output buffer entries; power of two, minimum 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 in_valid  input  1  one-cycle strobe from divider: final quotient/remainder present this cycle.
REQ-006 quotient_mag  input  WORD_LENGTH  unsigned quotient magnitude from divider.
REQ-007 remainder_mag  input  WORD_LENGTH  unsigned remainder magnitude from divider.
REQ-008 sign  input  1  quotient sign from divider (dividend sign XOR divisor sign).
REQ-009 dividend_sign  input  1  sign of original dividend; governs remainder sign.
REQ-010 divisor_zero  input  1  original divisor was zero.
REQ-011 out_ready  input  1  downstream consumer accepts the head entry.
REQ-012 out_valid  output  1  head entry valid.
REQ-013 out_quotient  output  WORD_LENGTH  signed two's-complement quotient.
REQ-014 out_remainder  output  WORD_LENGTH  signed two's-complement remainder.
REQ-015 out_div0  output  1  head entry is a divide-by-zero result.
REQ-016 full  output  1  buffer holds DEPTH entries.
REQ-017 count  output  $clog2(DEPTH)+1  entries currently held.
REQ-018 overflow  output  1  sticky: a result was dropped.

Function
REQ-019 Sign fix: stored quotient SHALL be sign ? (~quotient_mag + 1) : quotient_mag, modulo 2^WORD_LENGTH.
REQ-020 Stored remainder SHALL be dividend_sign ? (~remainder_mag + 1) : remainder_mag, modulo 2^WORD_LENGTH; zero magnitude stays zero.
REQ-021 divisor_zero=1: stored quotient SHALL be all ones, remainder the sign-fixed remainder_mag, div0 flag 1; otherwise div0 flag 0.
REQ-022 Push: in_valid=1 and (full=0 or pop this cycle) writes entry at write pointer; count increments unless a pop also occurs.
REQ-023 Pop: out_valid=1 and out_ready=1 advances read pointer; count decrements unless a push also occurs.
REQ-024 Simultaneous push and pop when full SHALL be accepted; count stays DEPTH, no overflow.
REQ-025 Simultaneous push and pop when count=1: count stays 1; the new entry appears on the head next cycle.
REQ-026 in_valid=1 while full and no pop: entry SHALL be dropped, buffer unchanged, overflow set next cycle and held until reset.
REQ-027 Latency: push at cycle N into empty buffer gives out_valid=1 with that entry at cycle N+1.
REQ-028 out_valid SHALL equal (count != 0); head data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-029 Pointers SHALL wrap from DEPTH-1 to 0; out_ready with out_valid=0 has no effect.
REQ-030 Entry order SHALL be strict FIFO.

Reset
REQ-031 reset=0 at a rising edge SHALL clear pointers, count, overflow; out_valid=0, full=0, count=0.
REQ-032 out_quotient, out_remainder, out_div0 SHALL read 0 after reset until the first push.
REQ-033 reset mid-operation SHALL discard all held entries; in_valid during reset is ignored.

Structure
REQ-034 Shared package div_pkg SHALL hold the WORD_LENGTH default and the result-entry struct typedef (quotient, remainder, div0).
REQ-035 Storage and pointers SHALL reside in one sub-module div_result_fifo; sign-fix logic stays in the top.

Verification
REQ-036 quotient_mag=7, remainder_mag=2, sign=1, dividend_sign=1 (-23/3) -> next cycle out_quotient=0xFFF9, out_remainder=0xFFFE, out_valid=1.
REQ-037 quotient_mag=5, remainder_mag=0, sign=0, dividend_sign=1 -> out_quotient=5, out_remainder=0.
REQ-038 divisor_zero=1, remainder_mag=9, dividend_sign=0 -> out_quotient=0xFFFF, out_remainder=9, out_div0=1.
REQ-039 out_ready=0, five pushes with DEPTH=4 -> full=1, count=4, overflow=1; then drain yields the first four in order.
REQ-040 Full buffer, in_valid=1 with out_ready=1 same cycle -> count=4, overflow=0, new entry appears fourth.
REQ-041 Three entries held, reset=0 for one cycle -> count=0, out_valid=0, overflow=0, outputs 0.
